lcd_rgb_rx: RTL and testbench
=============================

LCD_RGB_RX -- requirements
Module: lcd_rgb_rx

Interface
REQ-001 Parameter H_ACTIVE, default 480, expected DE-high pixels per line.
REQ-002 Parameter V_ACTIVE, default 272, expected DE-high lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive good frames needed to lock.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 PixelClk  in  1  pixel clock; all logic on its rising edge.
REQ-006 nRST  in  1  asynchronous, active-low reset.
REQ-007 LCD_DE  in  1  data enable, active high.
REQ-008 LCD_HSYNC  in  1  line sync, active low.
REQ-009 LCD_VSYNC  in  1  frame sync, active low.
REQ-010 LCD_R / LCD_G / LCD_B  in  5 / 6 / 5  RGB565 pixel data.
REQ-011 pix_valid  out  1  captured pixel strobe.
REQ-012 pix_rgb  out  16  captured pixel data {R,G,B}.
REQ-013 pix_x / pix_y  out  9 / 9  pixel column and active-line index.
REQ-014 frame_start  out  1  one-cycle pulse per frame.
REQ-015 meas_width / meas_height  out  10 / 10  last measured line width and frame height.
REQ-016 locked  out  1  geometry matches parameters.
REQ-017 err  out  1  one-cycle pulse on loss of lock.

Function
REQ-018 All inputs SHALL be registered once (stage 1); edges SHALL be detected between stage 1 and a stage-2 copy.
REQ-019 Frame edge = VSYNC falling; line start = DE rising; line end = DE falling; HSYNC is ignored for geometry.
REQ-020 x counter: cleared to 0 on DE rising; +1 per DE-high cycle; saturates at 511.
REQ-021 Width counter: 10 bits, saturating at 1023; copied to meas_width on DE falling.
REQ-022 y counter: cleared on frame edge; +1 on DE falling; saturates at 511.
REQ-023 Line counter (10 bits, saturating) SHALL be copied to meas_height on frame edge.
REQ-024 A line is bad if its width != H_ACTIVE. A frame is bad if any line was bad or its height != V_ACTIVE.
REQ-025 The FSM SHALL have states SEARCH, MEASURE and LOCKED.
REQ-026 SEARCH -> MEASURE on the first frame edge.
REQ-027 In MEASURE, each frame edge SHALL evaluate the closing frame: good increments good_cnt, bad clears it; at good_cnt == LOCK_FRAMES go to LOCKED.
REQ-028 In LOCKED, a bad line SHALL cause an immediate transition (next cycle) to SEARCH with a one-cycle err pulse, and locked SHALL deassert in the same cycle.
REQ-029 locked SHALL be high iff state == LOCKED.
REQ-030 pix_valid, pix_rgb, pix_x and pix_y SHALL update 2 PixelClk after LCD_DE at the pins, and only in LOCKED; otherwise pix_valid = 0.
REQ-031 frame_start SHALL pulse one cycle on each frame edge while in LOCKED, including the edge that enters LOCKED.
REQ-032 On a frame edge and DE rising in the same cycle, the frame clear SHALL apply first, so the pixel is x=0, y=0.
REQ-033 Width > 511 SHALL saturate pix_x at 511 and be flagged as a bad line.

Reset
REQ-034 While nRST is low, all outputs SHALL be 0: pix_valid=0, pix_rgb=0, pix_x=0, pix_y=0, frame_start=0, meas_width=0, meas_height=0, locked=0, err=0.
REQ-035 While nRST is low, the state SHALL be SEARCH and all counters and good_cnt SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a new frame edge.
REQ-037 nRST assertion SHALL take effect asynchronously; release SHALL be treated as synchronous to PixelClk.

Structure
REQ-038 The shared package lcd_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, the counter widths, the rgb565 struct and the rx state enum.
REQ-039 Sub-module lcd_sync_sampler SHALL provide the input registers and the DE/VSYNC edge pulses; the rest stays in lcd_rgb_rx.

Verification
REQ-040 480x272 timing frames from reset -> locked rises at the 3rd VSYNC fall (2 good frames); frame_start pulses there; meas_width=480, meas_height=272.
REQ-041 Locked stream with R=5'h1F, G=0, B=0 at x=10, y=20 -> pix_rgb=16'hF800, pix_x=10, pix_y=20, 2 cycles after DE at the pins.
REQ-042 While locked, one line with width 479 -> err pulses once, locked=0 the next cycle, pix_valid stays 0 until relock after 2 good frames.
REQ-043 DE held high for 600 cycles -> pix_x saturates at 511, meas_width=600, frame bad, no lock.
REQ-044 nRST pulsed low mid-line while locked -> all outputs 0 at once; relock requires 1 + LOCK_FRAMES frame edges.
REQ-045 Frame edge coincident with DE rising -> first captured pixel of the frame has pix_x=0, pix_y=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD RGB565 receiver.
//   - default active geometry and lock depth
//   - counter widths for column, row and measurement counters
//   - rgb565_t pixel struct and rx_state_t receiver state enum
package lcd_pkg;

    localparam int H_ACTIVE_DEF    = 480;
    localparam int V_ACTIVE_DEF    = 272;
    localparam int LOCK_FRAMES_DEF = 2;

    localparam int X_W = 9;   // pixel column index
    localparam int Y_W = 9;   // active-line index
    localparam int W_W = 10;  // measured width / height

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/lcd_sync_sampler.sv
// Input register stage for the LCD receiver.
//   clk, rst_n           : pixel clock, async active-low reset
//   lcd_de/hsync/vsync   : raw sync inputs
//   lcd_rgb              : raw pixel data
//   de_q, hsync_q, rgb_q : stage-1 registered copies
//   de_rise, de_fall     : DE edges between stage 1 and stage 2
//   frame_edge           : VSYNC falling between stage 1 and stage 2
module lcd_sync_sampler
    import lcd_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    lcd_de,
    input  logic    lcd_hsync,
    input  logic    lcd_vsync,
    input  rgb565_t lcd_rgb,
    output logic    de_q,
    output logic    hsync_q,
    output rgb565_t rgb_q,
    output logic    de_rise,
    output logic    de_fall,
    output logic    frame_edge
);

    logic de_q2;
    logic vsync_q;
    logic vsync_q2;

    // VSYNC stages reset low so a frame edge needs a real high-to-low
    // transition after reset; a frame in progress at reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q     <= 1'b0;
            de_q2    <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            vsync_q2 <= 1'b0;
            rgb_q    <= '0;
        end else begin
            de_q     <= lcd_de;
            de_q2    <= de_q;
            hsync_q  <= lcd_hsync;
            vsync_q  <= lcd_vsync;
            vsync_q2 <= vsync_q;
            rgb_q    <= lcd_rgb;
        end
    end

    always_comb begin
        de_rise    = de_q & ~de_q2;
        de_fall    = ~de_q & de_q2;
        frame_edge = ~vsync_q & vsync_q2;
    end

endmodule

// File: rtl/lcd_rgb_rx.sv
// LCD RGB565 parallel receiver with geometry measurement and lock detection.
//   PixelClk, nRST            : pixel clock, async active-low reset
//   LCD_DE/HSYNC/VSYNC        : data enable, line sync, frame sync
//   LCD_R/G/B                 : RGB565 pixel data
//   pix_valid/rgb/x/y         : captured pixel stream (only while locked)
//   frame_start               : pulse per frame edge while locked
//   meas_width/meas_height    : last measured line width / frame height
//   locked, err               : lock status, one-cycle loss-of-lock pulse
module lcd_rgb_rx
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic           PixelClk,
    input  logic           nRST,
    input  logic           LCD_DE,
    input  logic           LCD_HSYNC,
    input  logic           LCD_VSYNC,
    input  logic [4:0]     LCD_R,
    input  logic [5:0]     LCD_G,
    input  logic [4:0]     LCD_B,
    output logic           pix_valid,
    output logic [15:0]    pix_rgb,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           frame_start,
    output logic [W_W-1:0] meas_width,
    output logic [W_W-1:0] meas_height,
    output logic           locked,
    output logic           err
);

    localparam int GC_W = $clog2(LOCK_FRAMES + 2);

    rgb565_t   rgb_in, rgb_q;
    logic      de_q, hsync_q, de_rise, de_fall, frame_edge;
    logic      hsync_unused;
    rx_state_t state, state_nxt;

    logic [X_W-1:0]  x_cnt, x_idx;
    logic [Y_W-1:0]  y_cnt, y_idx;
    logic [W_W-1:0]  w_cnt, h_cnt, h_base;
    logic [GC_W-1:0] good_cnt, good_inc;
    logic            line_bad_seen, line_bad, frame_good, capture;
    logic            err_q, fs_q;

    assign rgb_in       = '{r: LCD_R, g: LCD_G, b: LCD_B};
    assign hsync_unused = hsync_q;

    lcd_sync_sampler u_sampler (
        .clk        (PixelClk),
        .rst_n      (nRST),
        .lcd_de     (LCD_DE),
        .lcd_hsync  (LCD_HSYNC),
        .lcd_vsync  (LCD_VSYNC),
        .lcd_rgb    (rgb_in),
        .de_q       (de_q),
        .hsync_q    (hsync_q),
        .rgb_q      (rgb_q),
        .de_rise    (de_rise),
        .de_fall    (de_fall),
        .frame_edge (frame_edge)
    );

    // Index of the pixel in stage 1: a frame edge clears y before a
    // coincident DE rise uses it, so that pixel is (0,0).
    always_comb begin
        x_idx      = de_rise    ? '0 : x_cnt;
        y_idx      = frame_edge ? '0 : y_cnt;
        h_base     = frame_edge ? '0 : h_cnt;
        line_bad   = de_fall && (w_cnt != W_W'(H_ACTIVE));
        frame_good = !line_bad_seen && (h_cnt == W_W'(V_ACTIVE));
        good_inc   = good_cnt + 1'b1;
        capture    = de_q && (state_nxt == ST_LOCKED);
    end

    // State register
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) state <= ST_SEARCH;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SEARCH:  if (frame_edge) state_nxt = ST_MEASURE;
            ST_MEASURE: if (frame_edge && frame_good && good_inc == GC_W'(LOCK_FRAMES))
                            state_nxt = ST_LOCKED;
            ST_LOCKED:  if (line_bad) state_nxt = ST_SEARCH;
            default:    state_nxt = ST_SEARCH;
        endcase
    end

    // Output logic
    always_comb begin
        locked      = (state == ST_LOCKED);
        err         = err_q;
        frame_start = fs_q;
    end

    // Geometry counters, good-frame count and captured pixel registers.
    // x_cnt/y_cnt hold the index the next pixel/line will take.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            x_cnt         <= '0;
            y_cnt         <= '0;
            w_cnt         <= '0;
            h_cnt         <= '0;
            line_bad_seen <= 1'b0;
            good_cnt      <= '0;
            meas_width    <= '0;
            meas_height   <= '0;
            pix_valid     <= 1'b0;
            pix_rgb       <= '0;
            pix_x         <= '0;
            pix_y         <= '0;
            err_q         <= 1'b0;
            fs_q          <= 1'b0;
        end else begin
            if (de_q) begin
                x_cnt <= (x_idx == '1) ? x_idx : x_idx + 1'b1;
                if (de_rise)          w_cnt <= W_W'(1);
                else if (w_cnt != '1) w_cnt <= w_cnt + 1'b1;
            end
            y_cnt <= (de_fall && y_idx  != '1) ? y_idx  + 1'b1 : y_idx;
            h_cnt <= (de_fall && h_base != '1) ? h_base + 1'b1 : h_base;

            if (frame_edge) begin
                meas_height   <= h_cnt;
                line_bad_seen <= 1'b0;
            end
            if (de_fall) begin
                meas_width <= w_cnt;
                if (line_bad) line_bad_seen <= 1'b1;
            end

            if (state != ST_MEASURE) good_cnt <= '0;
            else if (frame_edge)     good_cnt <= frame_good ? good_inc : '0;

            pix_valid <= capture;
            if (capture) begin
                pix_rgb <= rgb_q;
                pix_x   <= x_idx;
                pix_y   <= y_idx;
            end

            err_q <= (state == ST_LOCKED) && (state_nxt == ST_SEARCH);
            fs_q  <= frame_edge && (state_nxt == ST_LOCKED);
        end
    end

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Self-checking bench for lcd_rgb_rx.
//   Directed frames drive the pins; a frame/line-level model derives the
//   expected outputs, compared every cycle two clocks after the pins.
//   Literal probes pin the model at lock entry, pixel capture, errors,
//   saturation and reset.
module tb_lcd_rgb_rx;

    localparam int H  = 32;
    localparam int V  = 24;
    localparam int LF = 2;

    typedef struct packed {
        logic        v;
        logic [15:0] rgb;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        fs;
        logic [9:0]  mw;
        logic [9:0]  mh;
        logic        lk;
        logic        er;
    } exp_t;

    logic        PixelClk = 1'b0;
    logic        nRST, LCD_DE, LCD_HSYNC, LCD_VSYNC;
    logic [4:0]  LCD_R, LCD_B;
    logic [5:0]  LCD_G;
    logic        pix_valid, frame_start, locked, err;
    logic [15:0] pix_rgb;
    logic [8:0]  pix_x, pix_y;
    logic [9:0]  meas_width, meas_height;

    lcd_rgb_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LF)) dut (
        .PixelClk    (PixelClk),
        .nRST        (nRST),
        .LCD_DE      (LCD_DE),
        .LCD_HSYNC   (LCD_HSYNC),
        .LCD_VSYNC   (LCD_VSYNC),
        .LCD_R       (LCD_R),
        .LCD_G       (LCD_G),
        .LCD_B       (LCD_B),
        .pix_valid   (pix_valid),
        .pix_rgb     (pix_rgb),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .locked      (locked),
        .err         (err)
    );

    always #5 PixelClk = ~PixelClk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int rst_hold = 0;
    int vs_low_left = 0;
    int p_lock = -10, p_pix = -10, p_first = -10, p_err = -10, p_sat = -10;
    int p_err_w = 0, p_sat_y = 0;
    bit p_lock_exp = 1'b0;
    exp_t exp_now = '0, e1 = '0, e2 = '0;

    // model state: pin history, line/frame geometry, lock bookkeeping
    bit   m_pde, m_pvs, m_bad, m_locked;
    int   m_w, m_lines, m_edges, m_run;
    logic [15:0] m_rgb;
    int   m_x, m_y, m_mw, m_mh;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, got, expv);
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [15:0] pat(input int x, input int y);
        return 16'((x * 37 + y * 101 + 7) & 16'hFFFF);
    endfunction

    task automatic model_reset();
        m_pde = 0; m_pvs = 0; m_bad = 0; m_locked = 0;
        m_w = 0; m_lines = 0; m_edges = 0; m_run = 0;
        m_rgb = '0; m_x = 0; m_y = 0; m_mw = 0; m_mh = 0;
    endtask

    task automatic model_step(input bit de, input bit vs, input logic [15:0] rgb);
        bit rise, fall, fe, good;
        exp_t e;
        rise = de && !m_pde;
        fall = !de && m_pde;
        fe   = !vs && m_pvs;
        m_pde = de;
        m_pvs = vs;
        e = '0;
        if (fe) begin
            good = !m_bad && (m_lines == V);
            m_mh = min_i(m_lines, 1023);
            if (!m_locked) begin
                // the frame cut by the first edge after search is not judged
                if (m_edges > 0) m_run = good ? m_run + 1 : 0;
                m_edges++;
                if (m_run >= LF) m_locked = 1;
            end
            m_lines = 0;
            m_bad = 0;
            e.fs = m_locked;
        end
        if (rise) m_w = 0;
        if (de) begin
            if (m_locked) begin
                e.v = 1'b1;
                m_rgb = rgb;
                m_x = min_i(m_w, 511);
                m_y = min_i(m_lines, 511);
            end
            m_w++;
        end
        if (fall) begin
            m_mw = min_i(m_w, 1023);
            m_lines++;
            if (m_w != H) begin
                m_bad = 1;
                if (m_locked) begin
                    m_locked = 0;
                    e.er = 1'b1;
                    m_edges = 0;
                    m_run = 0;
                end
            end
        end
        e.rgb = m_rgb;
        e.x   = 9'(m_x);
        e.y   = 9'(m_y);
        e.mw  = 10'(m_mw);
        e.mh  = 10'(m_mh);
        e.lk  = m_locked;
        exp_now = e;
    endtask

    task automatic probes();
        if (cyc_n == p_lock) begin
            check("lock_locked", locked, p_lock_exp);
            check("lock_frame_start", frame_start, p_lock_exp);
            if (p_lock_exp) begin
                check("lock_meas_width", meas_width, H);
                check("lock_meas_height", meas_height, V);
            end
        end
        if (cyc_n == p_pix) begin
            check("red_valid", pix_valid, 1);
            check("red_rgb", pix_rgb, 16'hF800);
            check("red_x", pix_x, 10);
            check("red_y", pix_y, 20);
        end
        if (cyc_n == p_first) begin
            check("coinc_valid", pix_valid, 1);
            check("coinc_x", pix_x, 0);
            check("coinc_y", pix_y, 0);
        end
        if (cyc_n == p_err) begin
            check("err_pulse", err, 1);
            check("err_locked", locked, 0);
            check("err_meas_width", meas_width, p_err_w);
        end
        if (cyc_n == p_err + 1) check("err_one_cycle", err, 0);
        if (cyc_n == p_sat) begin
            check("sat_valid", pix_valid, 1);
            check("sat_x", pix_x, 511);
            check("sat_y", pix_y, p_sat_y);
        end
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_rgb"}, pix_rgb, 0);
        check({tag, "_pix_x"}, pix_x, 0);
        check({tag, "_pix_y"}, pix_y, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_meas_width"}, meas_width, 0);
        check({tag, "_meas_height"}, meas_height, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // one pixel clock: VSYNC comes from vs_low_left
    task automatic cyc(input bit de, input logic [15:0] rgb);
        bit vs;
        @(negedge PixelClk);
        cyc_n++;
        probes();
        vs = (vs_low_left > 0) ? 1'b0 : 1'b1;
        if (vs_low_left > 0) vs_low_left--;
        LCD_DE    = de;
        LCD_VSYNC = vs;
        LCD_HSYNC = de;
        LCD_R     = rgb[15:11];
        LCD_G     = rgb[10:5];
        LCD_B     = rgb[4:0];
        if (rst_hold > 0) begin
            rst_hold--;
            model_reset();
            exp_now = '0;
        end else begin
            nRST = 1'b1;
            model_step(de, vs, rgb);
        end
    endtask

    task automatic async_reset();
        @(posedge PixelClk);
        #2;
        nRST = 1'b0;
        model_reset();
        exp_now = '0;
        e1 = '0;
        e2 = '0;
        rst_hold = 3;
        #1;
        zero_check("async_rst");
    endtask

    // probe: 0 none, 1 lock=0 at start, 2 lock=1 at start, 3 red pixel,
    //        4 err at odd line, 5 err + x saturation on odd line
    task automatic frame(input int odd_line, input int odd_w, input bit coinc,
                         input int probe, input bit do_rst);
        int w;
        logic [15:0] px;
        vs_low_left = 3;
        if (!coinc) begin
            cyc(0, '0);
            if (probe == 1 || probe == 2) begin
                p_lock = cyc_n + 2;
                p_lock_exp = (probe == 2);
            end
            repeat (4) cyc(0, '0);
        end
        for (int l = 0; l < V; l++) begin
            w = (l == odd_line) ? odd_w : H;
            for (int i = 0; i < w; i++) begin
                if (do_rst && l == 2 && i == 5) async_reset();
                px = (probe == 3 && l == 20 && i == 10) ? 16'hF800 : pat(i, l);
                cyc(1, px);
                if (coinc && l == 0 && i == 0) p_first = cyc_n + 2;
                if (probe == 3 && l == 20 && i == 10) p_pix = cyc_n + 2;
                if (probe == 5 && l == odd_line && i == 550) begin
                    p_sat = cyc_n + 2;
                    p_sat_y = l;
                end
            end
            cyc(0, '0);
            if ((probe == 4 || probe == 5) && l == odd_line) begin
                p_err = cyc_n + 2;
                p_err_w = w;
            end
            repeat (3) cyc(0, '0);
        end
    endtask

    // per-cycle comparison against the model, two clocks behind the pins
    always @(posedge PixelClk) begin
        exp_t got;
        e2 = e1;
        e1 = exp_now;
        #1;
        got = '{v: pix_valid, rgb: pix_rgb, x: pix_x, y: pix_y, fs: frame_start,
                mw: meas_width, mh: meas_height, lk: locked, er: err};
        check("cycle", got, e2);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0;
        LCD_DE = 1'b0; LCD_HSYNC = 1'b0; LCD_VSYNC = 1'b1;
        LCD_R = '0; LCD_G = '0; LCD_B = '0;
        model_reset();
        rst_hold = 3;
        repeat (2) cyc(0, '0);
        zero_check("reset");
        repeat (6) cyc(0, '0);

        frame(-1, 0, 0, 0, 0);      // edge 1: start measuring
        frame(-1, 0, 0, 1, 0);      // edge 2: one good frame
        frame(-1, 0, 0, 2, 0);      // edge 3: lock
        frame(-1, 0, 0, 3, 0);      // red pixel at (10,20)
        frame(-1, 0, 1, 0, 0);      // VSYNC fall with DE rise
        frame(5, H - 1, 0, 4, 0);   // short line -> loss of lock
        frame(-1, 0, 0, 1, 0);      // search -> measure
        frame(-1, 0, 0, 1, 0);
        frame(-1, 0, 0, 2, 0);      // relock
        frame(3, 600, 0, 5, 0);     // 600-wide line while locked
        frame(3, 600, 0, 1, 0);     // measuring, bad frame
        frame(-1, 0, 0, 1, 0);      // bad frame clears the count
        frame(-1, 0, 0, 1, 0);
        frame(-1, 0, 0, 2, 1);      // lock, then reset mid-line
        frame(-1, 0, 0, 1, 0);
        frame(-1, 0, 0, 1, 0);
        frame(-1, 0, 0, 2, 0);      // relock after 1 + LF edges
        repeat (8) cyc(0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
